decode_dispatch_stage: RTL and testbench

- Successor to the combinational decoder: a parametrised, buffered decode/dispatch stage.
- Holds fetched instructions in an IQ_DEPTH-entry circular instruction queue and decodes the head.
- Resolves operands through the register file and ROB, and renames rd.
- Dispatches into RS or LSB through a registered one-cycle pulse interface, with back-pressure, flush and illegal-instruction detection.

---
 rtl/decode_dispatch_stage.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_decode_dispatch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_stage.sv
// decode_dispatch_stage: buffered RV32I decode/dispatch stage.
// A circular instruction queue feeds a head decoder. The decoder resolves
// operands through the register file and ROB, renames rd, and dispatches
// to RS or LSB through registered one-cycle pulses.
// Optional feature: define RV32M_EN to decode the RV32M multiply/divide group.

`ifndef INSIDE_OP_LUI
`define INSIDE_OP_LUI    1
`define INSIDE_OP_AUIPC  2
`define INSIDE_OP_JAL    3
`define INSIDE_OP_JALR   4
`define INSIDE_OP_BEQ    5
`define INSIDE_OP_BNE    6
`define INSIDE_OP_BLT    7
`define INSIDE_OP_BGE    8
`define INSIDE_OP_BLTU   9
`define INSIDE_OP_BGEU   10
`define INSIDE_OP_LB     11
`define INSIDE_OP_LH     12
`define INSIDE_OP_LW     13
`define INSIDE_OP_LBU    14
`define INSIDE_OP_LHU    15
`define INSIDE_OP_SB     16
`define INSIDE_OP_SH     17
`define INSIDE_OP_SW     18
`define INSIDE_OP_ADDI   19
`define INSIDE_OP_SLTI   20
`define INSIDE_OP_SLTIU  21
`define INSIDE_OP_XORI   22
`define INSIDE_OP_ORI    23
`define INSIDE_OP_ANDI   24
`define INSIDE_OP_SLLI   25
`define INSIDE_OP_SRLI   26
`define INSIDE_OP_SRAI   27
`define INSIDE_OP_ADD    28
`define INSIDE_OP_SUB    29
`define INSIDE_OP_SLL    30
`define INSIDE_OP_SLT    31
`define INSIDE_OP_SLTU   32
`define INSIDE_OP_XOR    33
`define INSIDE_OP_SRL    34
`define INSIDE_OP_SRA    35
`define INSIDE_OP_OR     36
`define INSIDE_OP_AND    37
`define INSIDE_OP_MUL    38
`define INSIDE_OP_MULH   39
`define INSIDE_OP_MULHSU 40
`define INSIDE_OP_MULHU  41
`define INSIDE_OP_DIV    42
`define INSIDE_OP_DIVU   43
`define INSIDE_OP_REM    44
`define INSIDE_OP_REMU   45
`endif

module decode_dispatch_stage #(
   parameter int IQ_DEPTH  = 4,
   parameter int XLEN      = 32,
   parameter int ROB_TAG_W = 4,
   parameter int REG_TAG_W = 5,
   parameter int OP_W      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 in_fetch_valid,
   input  logic [XLEN-1:0]      in_fetch_instr,
   input  logic [XLEN-1:0]      in_fetch_pc,
   output logic                 out_fetch_ready,
   input  logic                 in_flush,
   output logic [REG_TAG_W-1:0] out_reg_tag1,
   output logic [REG_TAG_W-1:0] out_reg_tag2,
   input  logic [XLEN-1:0]      in_reg_value1,
   input  logic [XLEN-1:0]      in_reg_value2,
   input  logic [ROB_TAG_W-1:0] in_reg_robtag1,
   input  logic [ROB_TAG_W-1:0] in_reg_robtag2,
   input  logic                 in_reg_busy1,
   input  logic                 in_reg_busy2,
   output logic [ROB_TAG_W-1:0] out_rob_fetch_tag1,
   output logic [ROB_TAG_W-1:0] out_rob_fetch_tag2,
   input  logic [XLEN-1:0]      in_rob_fetch_value1,
   input  logic [XLEN-1:0]      in_rob_fetch_value2,
   input  logic                 in_rob_fetch_ready1,
   input  logic                 in_rob_fetch_ready2,
   input  logic                 in_rob_full,
   input  logic                 in_rs_full,
   input  logic                 in_lsb_full,
   input  logic [ROB_TAG_W-1:0] in_rob_freetag,
   output logic                 out_reg_rename_en,
   output logic [REG_TAG_W-1:0] out_reg_destination,
   output logic [ROB_TAG_W-1:0] out_reg_rob_tag,
   output logic                 out_dispatch_valid,
   output logic [1:0]           out_dispatch_unit,
   output logic [ROB_TAG_W-1:0] out_rob_tag,
   output logic [ROB_TAG_W-1:0] out_tag1,
   output logic [ROB_TAG_W-1:0] out_tag2,
   output logic [OP_W-1:0]      out_op,
   output logic [REG_TAG_W-1:0] out_rd,
   output logic [XLEN-1:0]      out_value1,
   output logic [XLEN-1:0]      out_value2,
   output logic [XLEN-1:0]      out_imm,
   output logic [XLEN-1:0]      out_pc,
   output logic                 out_illegal
);

   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(IQ_DEPTH);

   logic [XLEN-1:0] iq_instr [IQ_DEPTH];
   logic [XLEN-1:0] iq_pc    [IQ_DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;

   logic [XLEN-1:0] ins, head_pc;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [REG_TAG_W-1:0] rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic legal, use1, use2, wr_rd;
   logic [1:0] unit_sel;
   int unsigned op_i;
   logic [XLEN-1:0] imm, val1, val2;
   logic [ROB_TAG_W-1:0] tag1, tag2;
   logic active, has_head, unit_full, fire, drop_illegal, pop, push;

   assign ins     = iq_instr[head];
   assign head_pc = iq_pc[head];
   assign opcode  = ins[6:0];
   assign funct3  = ins[14:12];
   assign funct7  = ins[31:25];
   assign rd      = ins[11:7];

   assign imm_i  = {{(XLEN-11){ins[31]}}, ins[30:20]};
   assign imm_s  = {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]};
   assign imm_b  = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u  = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
   assign imm_j  = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
   assign imm_sh = {{(XLEN-5){1'b0}}, ins[24:20]};

   // Decode the queue head: legality, target unit, operand usage, op and immediate.
   always_comb begin
      legal = 1'b1; unit_sel = 2'd1; use1 = 1'b0; use2 = 1'b0; wr_rd = 1'b0;
      op_i = 0; imm = '0;
      case (opcode)
         7'b0110111: begin op_i = `INSIDE_OP_LUI;   wr_rd = 1'b1; imm = imm_u; end
         7'b0010111: begin op_i = `INSIDE_OP_AUIPC; wr_rd = 1'b1; imm = imm_u; end
         7'b1101111: begin op_i = `INSIDE_OP_JAL;   wr_rd = 1'b1; imm = imm_j; end
         7'b1100111: begin
            op_i = `INSIDE_OP_JALR; wr_rd = 1'b1; use1 = 1'b1; imm = imm_i;
            legal = (funct3 == 3'b000);
         end
         7'b1100011: begin
            use1 = 1'b1; use2 = 1'b1; imm = imm_b;
            case (funct3)
               3'b000:  op_i = `INSIDE_OP_BEQ;
               3'b001:  op_i = `INSIDE_OP_BNE;
               3'b100:  op_i = `INSIDE_OP_BLT;
               3'b101:  op_i = `INSIDE_OP_BGE;
               3'b110:  op_i = `INSIDE_OP_BLTU;
               3'b111:  op_i = `INSIDE_OP_BGEU;
               default: legal = 1'b0;
            endcase
         end
         7'b0000011: begin
            unit_sel = 2'd2; use1 = 1'b1; wr_rd = 1'b1; imm = imm_i;
            case (funct3)
               3'b000:  op_i = `INSIDE_OP_LB;
               3'b001:  op_i = `INSIDE_OP_LH;
               3'b010:  op_i = `INSIDE_OP_LW;
               3'b100:  op_i = `INSIDE_OP_LBU;
               3'b101:  op_i = `INSIDE_OP_LHU;
               default: legal = 1'b0;
            endcase
         end
         7'b0100011: begin
            unit_sel = 2'd2; use1 = 1'b1; use2 = 1'b1; imm = imm_s;
            case (funct3)
               3'b000:  op_i = `INSIDE_OP_SB;
               3'b001:  op_i = `INSIDE_OP_SH;
               3'b010:  op_i = `INSIDE_OP_SW;
               default: legal = 1'b0;
            endcase
         end
         7'b0010011: begin
            use1 = 1'b1; wr_rd = 1'b1; imm = imm_i;
            case (funct3)
               3'b000: op_i = `INSIDE_OP_ADDI;
               3'b010: op_i = `INSIDE_OP_SLTI;
               3'b011: op_i = `INSIDE_OP_SLTIU;
               3'b100: op_i = `INSIDE_OP_XORI;
               3'b110: op_i = `INSIDE_OP_ORI;
               3'b111: op_i = `INSIDE_OP_ANDI;
               3'b001: begin
                  op_i = `INSIDE_OP_SLLI; imm = imm_sh;
                  legal = (funct7 == 7'b0000000);
               end
               default: begin
                  imm = imm_sh;
                  if (funct7 == 7'b0000000)      op_i = `INSIDE_OP_SRLI;
                  else if (funct7 == 7'b0100000) op_i = `INSIDE_OP_SRAI;
                  else                           legal = 1'b0;
               end
            endcase
         end
         7'b0110011: begin
            use1 = 1'b1; use2 = 1'b1; wr_rd = 1'b1;
            case (funct7)
               7'b0000000: begin
                  case (funct3)
                     3'b000:  op_i = `INSIDE_OP_ADD;
                     3'b001:  op_i = `INSIDE_OP_SLL;
                     3'b010:  op_i = `INSIDE_OP_SLT;
                     3'b011:  op_i = `INSIDE_OP_SLTU;
                     3'b100:  op_i = `INSIDE_OP_XOR;
                     3'b101:  op_i = `INSIDE_OP_SRL;
                     3'b110:  op_i = `INSIDE_OP_OR;
                     default: op_i = `INSIDE_OP_AND;
                  endcase
               end
               7'b0100000: begin
                  if (funct3 == 3'b000)      op_i = `INSIDE_OP_SUB;
                  else if (funct3 == 3'b101) op_i = `INSIDE_OP_SRA;
                  else                       legal = 1'b0;
               end
`ifdef RV32M_EN
               7'b0000001: begin
                  case (funct3)
                     3'b000:  op_i = `INSIDE_OP_MUL;
                     3'b001:  op_i = `INSIDE_OP_MULH;
                     3'b010:  op_i = `INSIDE_OP_MULHSU;
                     3'b011:  op_i = `INSIDE_OP_MULHU;
                     3'b100:  op_i = `INSIDE_OP_DIV;
                     3'b101:  op_i = `INSIDE_OP_DIVU;
                     3'b110:  op_i = `INSIDE_OP_REM;
                     default: op_i = `INSIDE_OP_REMU;
                  endcase
               end
`else
               7'b0000001: legal = 1'b0;
`endif
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
   end

   // Packs {value, tag}: x0 or unused -> 0; ready register -> value; ready ROB -> value; else wait on tag.
   function automatic logic [XLEN+ROB_TAG_W-1:0] resolve(
      input logic used, input logic [REG_TAG_W-1:0] rs,
      input logic [XLEN-1:0] reg_val, input logic [ROB_TAG_W-1:0] reg_tag, input logic busy,
      input logic [XLEN-1:0] rob_val, input logic rob_rdy);
      if (!used || rs == '0) resolve = '0;
      else if (!busy)        resolve = {reg_val, {ROB_TAG_W{1'b0}}};
      else if (rob_rdy)      resolve = {rob_val, {ROB_TAG_W{1'b0}}};
      else                   resolve = {{XLEN{1'b0}}, reg_tag};
   endfunction

   assign {val1, tag1} = resolve(use1, ins[19:15], in_reg_value1, in_reg_robtag1, in_reg_busy1,
                                 in_rob_fetch_value1, in_rob_fetch_ready1);
   assign {val2, tag2} = resolve(use2, ins[24:20], in_reg_value2, in_reg_robtag2, in_reg_busy2,
                                 in_rob_fetch_value2, in_rob_fetch_ready2);

   assign out_reg_tag1        = ins[19:15];
   assign out_reg_tag2        = ins[24:20];
   assign out_rob_fetch_tag1  = in_reg_robtag1;
   assign out_rob_fetch_tag2  = in_reg_robtag2;

   // Illegal heads are dropped regardless of back-pressure; legal heads need ROB and target room.
   assign active       = rdy && !in_flush && !rst;
   assign has_head     = (count != '0);
   assign unit_full    = (unit_sel == 2'd2) ? in_lsb_full : in_rs_full;
   assign fire         = active && has_head && legal && !in_rob_full && !unit_full;
   assign drop_illegal = active && has_head && !legal;
   assign pop          = fire || drop_illegal;
   assign out_fetch_ready = !rst && (count != FULL_CNT);
   assign push         = in_fetch_valid && out_fetch_ready && rdy && !in_flush;

   assign out_reg_rename_en   = fire && wr_rd && (rd != '0);
   assign out_reg_destination = rd;
   assign out_reg_rob_tag     = in_rob_freetag;

   // Queue storage; write-only on push, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         iq_instr[tail] <= in_fetch_instr;
         iq_pc[tail]    <= in_fetch_pc;
      end
   end

   // Queue pointers, occupancy and the registered dispatch interface.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0; tail <= '0; count <= '0;
         out_dispatch_valid <= 1'b0; out_dispatch_unit <= '0; out_rob_tag <= '0;
         out_tag1 <= '0; out_tag2 <= '0; out_op <= '0; out_rd <= '0;
         out_value1 <= '0; out_value2 <= '0; out_imm <= '0; out_pc <= '0;
         out_illegal <= 1'b0;
      end else if (in_flush) begin
         head <= '0; tail <= '0; count <= '0;
         out_dispatch_valid <= 1'b0; out_illegal <= 1'b0;
      end else begin
         out_dispatch_valid <= fire;
         out_illegal        <= drop_illegal;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         if (fire) begin
            out_dispatch_unit <= unit_sel;
            out_rob_tag       <= in_rob_freetag;
            out_tag1          <= tag1;
            out_tag2          <= tag2;
            out_op            <= OP_W'(op_i);
            out_rd            <= wr_rd ? rd : '0;
            out_value1        <= val1;
            out_value2        <= val2;
            out_imm           <= imm;
            out_pc            <= head_pc;
         end
      end
   end

endmodule

// File: tb/tb_decode_dispatch_stage.sv
// tb_decode_dispatch_stage: directed self-checking bench for decode_dispatch_stage.
// Honours RV32M_EN for the MUL expectation.

module tb_decode_dispatch_stage;

   localparam int unsigned OP_BLTU = 9;
   localparam int unsigned OP_SW   = 18;
   localparam int unsigned OP_ADDI = 19;
   localparam int unsigned OP_SRAI = 27;
   localparam int unsigned OP_ADD  = 28;
   localparam int unsigned OP_MUL  = 38;

   logic        clk = 1'b0;
   logic        rst, rdy, in_fetch_valid, in_flush;
   logic [31:0] in_fetch_instr, in_fetch_pc;
   logic [31:0] in_reg_value1, in_reg_value2, in_rob_fetch_value1, in_rob_fetch_value2;
   logic [3:0]  in_reg_robtag1, in_reg_robtag2, in_rob_freetag;
   logic        in_reg_busy1, in_reg_busy2, in_rob_fetch_ready1, in_rob_fetch_ready2;
   logic        in_rob_full, in_rs_full, in_lsb_full;

   logic        out_fetch_ready, out_reg_rename_en, out_dispatch_valid, out_illegal;
   logic [4:0]  out_reg_tag1, out_reg_tag2, out_reg_destination, out_rd;
   logic [3:0]  out_rob_fetch_tag1, out_rob_fetch_tag2, out_reg_rob_tag;
   logic [3:0]  out_rob_tag, out_tag1, out_tag2;
   logic [1:0]  out_dispatch_unit;
   logic [5:0]  out_op;
   logic [31:0] out_value1, out_value2, out_imm, out_pc;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   decode_dispatch_stage dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .in_fetch_valid(in_fetch_valid), .in_fetch_instr(in_fetch_instr), .in_fetch_pc(in_fetch_pc),
      .out_fetch_ready(out_fetch_ready), .in_flush(in_flush),
      .out_reg_tag1(out_reg_tag1), .out_reg_tag2(out_reg_tag2),
      .in_reg_value1(in_reg_value1), .in_reg_value2(in_reg_value2),
      .in_reg_robtag1(in_reg_robtag1), .in_reg_robtag2(in_reg_robtag2),
      .in_reg_busy1(in_reg_busy1), .in_reg_busy2(in_reg_busy2),
      .out_rob_fetch_tag1(out_rob_fetch_tag1), .out_rob_fetch_tag2(out_rob_fetch_tag2),
      .in_rob_fetch_value1(in_rob_fetch_value1), .in_rob_fetch_value2(in_rob_fetch_value2),
      .in_rob_fetch_ready1(in_rob_fetch_ready1), .in_rob_fetch_ready2(in_rob_fetch_ready2),
      .in_rob_full(in_rob_full), .in_rs_full(in_rs_full), .in_lsb_full(in_lsb_full),
      .in_rob_freetag(in_rob_freetag),
      .out_reg_rename_en(out_reg_rename_en), .out_reg_destination(out_reg_destination),
      .out_reg_rob_tag(out_reg_rob_tag),
      .out_dispatch_valid(out_dispatch_valid), .out_dispatch_unit(out_dispatch_unit),
      .out_rob_tag(out_rob_tag), .out_tag1(out_tag1), .out_tag2(out_tag2),
      .out_op(out_op), .out_rd(out_rd),
      .out_value1(out_value1), .out_value2(out_value2), .out_imm(out_imm), .out_pc(out_pc),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      in_fetch_valid = 1'b1;
      in_fetch_instr = instr;
      in_fetch_pc    = pc;
      step();
      in_fetch_valid = 1'b0;
   endtask

   // ADDI rd, x0, imm
   function automatic logic [31:0] addi_enc(input logic [4:0] rd, input logic [11:0] imm);
      addi_enc = {imm, 5'd0, 3'd0, rd, 7'h13};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; in_fetch_valid = 1'b0; in_flush = 1'b0;
      in_fetch_instr = '0; in_fetch_pc = '0;
      in_reg_value1 = '0; in_reg_value2 = '0; in_rob_fetch_value1 = '0; in_rob_fetch_value2 = '0;
      in_reg_robtag1 = '0; in_reg_robtag2 = '0; in_rob_freetag = 4'd3;
      in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0; in_rob_fetch_ready1 = 1'b0; in_rob_fetch_ready2 = 1'b0;
      in_rob_full = 1'b0; in_rs_full = 1'b0; in_lsb_full = 1'b0;
      step(); step();
      check("rst_fetch_ready", 32'(out_fetch_ready), 0);
      check("rst_valid", 32'(out_dispatch_valid), 0);
      check("rst_illegal", 32'(out_illegal), 0);
      check("rst_op", 32'(out_op), 0);
      check("rst_pc", out_pc, 0);
      rst = 1'b0; #1;
      check("ready_after_rst", 32'(out_fetch_ready), 1);

      // ADDI x1,x0,5 into empty queue
      push(32'h00500093, 32'h100);
      check("addi_rename_en", 32'(out_reg_rename_en), 1);
      check("addi_rename_rd", 32'(out_reg_destination), 1);
      check("addi_rename_tag", 32'(out_reg_rob_tag), 3);
      check("addi_not_early", 32'(out_dispatch_valid), 0);
      step();
      check("addi_valid", 32'(out_dispatch_valid), 1);
      check("addi_unit", 32'(out_dispatch_unit), 1);
      check("addi_op", 32'(out_op), OP_ADDI);
      check("addi_rd", 32'(out_rd), 1);
      check("addi_value1", out_value1, 0);
      check("addi_tag1", 32'(out_tag1), 0);
      check("addi_imm", out_imm, 5);
      check("addi_robtag", 32'(out_rob_tag), 3);
      check("addi_pc", out_pc, 32'h100);
      step();
      check("addi_pulse_end", 32'(out_dispatch_valid), 0);
      check("addi_imm_hold", out_imm, 5);

      // Fill behind a full RS, then drain with a push in the first free cycle
      in_rs_full = 1'b1;
      for (int k = 1; k <= 4; k++) push(addi_enc(5'(k), 12'(k)), 32'h200 + 32'(4 * k));
      check("full_fetch_ready", 32'(out_fetch_ready), 0);
      check("full_no_dispatch", 32'(out_dispatch_valid), 0);
      in_fetch_valid = 1'b1; in_fetch_instr = addi_enc(5'd5, 12'd5); in_fetch_pc = 32'h214;
      in_rs_full = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 2) in_fetch_valid = 1'b0;
         if (k == 1) check("drain_ready", 32'(out_fetch_ready), 1);
         check($sformatf("drain%0d_valid", k), 32'(out_dispatch_valid), 1);
         check($sformatf("drain%0d_imm", k), out_imm, 32'(k));
         check($sformatf("drain%0d_rd", k), 32'(out_rd), 32'(k));
      end
      step();
      check("drain_done", 32'(out_dispatch_valid), 0);

      // ADD x2,x1,x1 with x1 renamed to tag 3
      in_reg_value1 = 32'd11; in_reg_value2 = 32'd13;
      in_rob_fetch_value1 = 32'd7; in_rob_fetch_value2 = 32'd7;
      in_reg_busy1 = 1'b1; in_reg_busy2 = 1'b1; in_reg_robtag1 = 4'd3; in_reg_robtag2 = 4'd3;
      push(32'h00108133, 32'h300);
      check("add_reg_tag1", 32'(out_reg_tag1), 1);
      check("add_rob_fetch_tag1", 32'(out_rob_fetch_tag1), 3);
      check("add_rename_rd", 32'(out_reg_destination), 2);
      step();
      check("add_busy_op", 32'(out_op), OP_ADD);
      check("add_busy_tag1", 32'(out_tag1), 3);
      check("add_busy_tag2", 32'(out_tag2), 3);
      check("add_busy_value1", out_value1, 0);
      check("add_busy_value2", out_value2, 0);
      in_rob_fetch_ready1 = 1'b1; in_rob_fetch_ready2 = 1'b1;
      push(32'h00108133, 32'h304);
      step();
      check("add_rob_valid", 32'(out_dispatch_valid), 1);
      check("add_rob_value1", out_value1, 7);
      check("add_rob_value2", out_value2, 7);
      check("add_rob_tag1", 32'(out_tag1), 0);
      in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0;
      push(32'h00108133, 32'h308);
      step();
      check("add_reg_value1", out_value1, 11);
      check("add_reg_value2", out_value2, 13);
      check("add_reg_tag2", 32'(out_tag2), 0);

      // SW x2,-4(x1): held by full LSB, unaffected by full RS
      in_reg_value1 = 32'h20; in_reg_value2 = 32'h55;
      in_rs_full = 1'b1; in_lsb_full = 1'b1;
      push(32'hFE20AE23, 32'h400);
      check("sw_rename_en", 32'(out_reg_rename_en), 0);
      step();
      check("sw_lsb_full_hold", 32'(out_dispatch_valid), 0);
      in_lsb_full = 1'b0;
      step();
      check("sw_valid", 32'(out_dispatch_valid), 1);
      check("sw_unit", 32'(out_dispatch_unit), 2);
      check("sw_op", 32'(out_op), OP_SW);
      check("sw_rd", 32'(out_rd), 0);
      check("sw_imm", out_imm, 32'hFFFFFFFC);
      check("sw_value1", out_value1, 32'h20);
      check("sw_value2", out_value2, 32'h55);
      in_rs_full = 1'b0;

      // BLTU x1,x2,+8
      push(32'h0020E463, 32'h404);
      check("bltu_rename_en", 32'(out_reg_rename_en), 0);
      step();
      check("bltu_op", 32'(out_op), OP_BLTU);
      check("bltu_imm", out_imm, 8);
      check("bltu_rd", 32'(out_rd), 0);
      check("bltu_unit", 32'(out_dispatch_unit), 1);

      // SRAI x1,x1,3: shamt immediate
      push(32'h4030D093, 32'h408);
      step();
      check("srai_op", 32'(out_op), OP_SRAI);
      check("srai_imm", out_imm, 3);

      // Flush with three queued and a dispatch pending; concurrent push dropped
      in_rs_full = 1'b1;
      for (int k = 1; k <= 3; k++) push(addi_enc(5'(k), 12'(k)), 32'h500 + 32'(4 * k));
      in_rs_full = 1'b0; in_flush = 1'b1;
      in_fetch_valid = 1'b1; in_fetch_instr = addi_enc(5'd9, 12'd9);
      #1;
      check("flush_no_rename", 32'(out_reg_rename_en), 0);
      step();
      in_flush = 1'b0; in_fetch_valid = 1'b0;
      check("flush_no_dispatch", 32'(out_dispatch_valid), 0);
      check("flush_ready", 32'(out_fetch_ready), 1);
      step();
      check("flush_empty", 32'(out_dispatch_valid), 0);
      push(addi_enc(5'd6, 12'd6), 32'h600);
      step();
      check("post_flush_valid", 32'(out_dispatch_valid), 1);
      check("post_flush_imm", out_imm, 6);
      step();
      check("post_flush_no_ghost", 32'(out_dispatch_valid), 0);

      // Illegal head is dropped despite back-pressure
      in_rob_full = 1'b1; in_rs_full = 1'b1;
      push(32'hFFFFFFFF, 32'h700);
      check("illegal_no_rename", 32'(out_reg_rename_en), 0);
      step();
      check("illegal_pulse", 32'(out_illegal), 1);
      check("illegal_no_dispatch", 32'(out_dispatch_valid), 0);
      step();
      check("illegal_pulse_end", 32'(out_illegal), 0);
      in_rob_full = 1'b0; in_rs_full = 1'b0;
      push(addi_enc(5'd7, 12'd7), 32'h704);
      step();
      check("after_illegal_valid", 32'(out_dispatch_valid), 1);
      check("after_illegal_imm", out_imm, 7);
      push(32'h02009093, 32'h708);
      step();
      check("slli_bit25_illegal", 32'(out_illegal), 1);
      check("slli_bit25_no_dispatch", 32'(out_dispatch_valid), 0);

      // rdy low stalls the head
      push(addi_enc(5'd8, 12'd8), 32'h800);
      rdy = 1'b0; #1;
      check("stall_no_rename", 32'(out_reg_rename_en), 0);
      step();
      check("stall_no_dispatch", 32'(out_dispatch_valid), 0);
      check("stall_imm_hold", out_imm, 7);
      rdy = 1'b1;
      step();
      check("unstall_valid", 32'(out_dispatch_valid), 1);
      check("unstall_imm", out_imm, 8);

      // MUL x0,x1,x2
      push(32'h02208033, 32'h900);
      step();
`ifdef RV32M_EN
      check("mul_valid", 32'(out_dispatch_valid), 1);
      check("mul_op", 32'(out_op), OP_MUL);
      check("mul_rd", 32'(out_rd), 0);
`else
      check("mul_illegal", 32'(out_illegal), 1);
      check("mul_no_dispatch", 32'(out_dispatch_valid), 0);
      check("mul_op_hold", 32'(out_op), OP_ADDI);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
